// File: rtl/ratioer.sv
// ratioer: measures drive and recovery phase lengths in clock cycles and
// computes the fixed-point ratio recovery/drive with a sequential restoring
// divider.
// Build option: define RATIOER_SAT_EN to make the phase counters saturate
// at their maximum value instead of wrapping.
// CNT_W + FRAC_W must equal 32.
module ratioer #(
  parameter int unsigned CNT_W  = 24,
  parameter int unsigned FRAC_W = 8
) (
  input  logic             count_clock,
  input  logic             reset,
  input  logic             start_drive,
  input  logic             start_recovery,
  output logic [31:0]      ratio,
  output logic             on_drive,
  output logic [CNT_W-1:0] drive_count,
  output logic [CNT_W-1:0] recovery_count,
  output logic             busy
);

  localparam int unsigned RATIO_W   = 32;
  localparam int unsigned ITER_W    = 5;
  localparam int unsigned LAST_ITER = RATIO_W - 1;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    RECOVERY
  } state_t;

  state_t state;

  // Divider working registers
  logic [RATIO_W-1:0] div_q;
  logic [CNT_W-1:0]   div_rem;
  logic [CNT_W-1:0]   div_d;
  logic [ITER_W-1:0]  div_cnt;

  // Next-iteration values of the divider
  logic [CNT_W:0]     trial;
  logic               fits;
  logic [CNT_W-1:0]   rem_next;
  logic [RATIO_W-1:0] q_next;

  logic snapshot;

  // Phase counter increment: saturating or wrapping depending on build
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
`ifdef RATIOER_SAT_EN
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
`else
    return v + CNT_W'(1);
`endif
  endfunction

  // A drive start that ends a recovery phase closes one measurement
  assign snapshot = start_drive && (state == RECOVERY);

  // Phase state machine and phase counters
  always_ff @(posedge count_clock) begin
    if (reset) begin
      state          <= IDLE;
      on_drive       <= 1'b0;
      drive_count    <= '0;
      recovery_count <= '0;
    end else if (start_drive) begin
      state       <= DRIVE;
      on_drive    <= 1'b1;
      drive_count <= CNT_W'(1);
      if (state == RECOVERY) begin
        recovery_count <= CNT_W'(1);
      end
    end else begin
      case (state)
        DRIVE: begin
          if (start_recovery) begin
            state          <= RECOVERY;
            on_drive       <= 1'b0;
            recovery_count <= CNT_W'(1);
          end else begin
            drive_count <= bump(drive_count);
          end
        end
        RECOVERY: begin
          recovery_count <= bump(recovery_count);
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // One restoring-division step: shift in next dividend bit, subtract if it fits
  always_comb begin
    trial    = {div_rem, div_q[RATIO_W-1]};
    fits     = (trial >= {1'b0, div_d});
    rem_next = fits ? CNT_W'(trial - {1'b0, div_d}) : CNT_W'(trial);
    q_next   = {div_q[RATIO_W-2:0], fits};
  end

  // Divider sequencing: snapshot restarts, 32 iterations, then publish ratio
  always_ff @(posedge count_clock) begin
    if (reset) begin
      busy    <= 1'b0;
      ratio   <= '0;
      div_q   <= '0;
      div_rem <= '0;
      div_d   <= '0;
      div_cnt <= '0;
    end else if (snapshot) begin
      busy    <= 1'b1;
      div_q   <= RATIO_W'({recovery_count, {FRAC_W{1'b0}}});
      div_rem <= '0;
      div_d   <= drive_count;
      div_cnt <= '0;
    end else if (busy) begin
      div_q   <= q_next;
      div_rem <= rem_next;
      div_cnt <= div_cnt + ITER_W'(1);
      if (div_cnt == ITER_W'(LAST_ITER)) begin
        busy  <= 1'b0;
        ratio <= (div_d == '0) ? {RATIO_W{1'b1}} : q_next;
      end
    end
  end

endmodule

// File: tb/tb_ratioer.sv
// Directed testbench for ratioer: default 24-bit instance plus a 4-bit
// counter instance for wrap/saturation and divide-by-zero behaviour.
module tb_ratioer;

  logic        clk;
  logic        reset;
  logic        sd;
  logic        sr;
  logic [31:0] ratio;
  logic        on_drive;
  logic [23:0] drive_count;
  logic [23:0] recovery_count;
  logic        busy;

  logic        sd4;
  logic        sr4;
  logic [31:0] ratio4;
  logic        on_drive4;
  logic [3:0]  drive4;
  logic [3:0]  rec4;
  logic        busy4;

  int vectors    = 0;
  int miscompares = 0;

  logic [31:0] exp_wrap_d;
  logic [31:0] exp_rec4;
  logic [31:0] exp_ratio4;

  ratioer dut (
    .count_clock    (clk),
    .reset          (reset),
    .start_drive    (sd),
    .start_recovery (sr),
    .ratio          (ratio),
    .on_drive       (on_drive),
    .drive_count    (drive_count),
    .recovery_count (recovery_count),
    .busy           (busy)
  );

  ratioer #(.CNT_W(4), .FRAC_W(28)) dut4 (
    .count_clock    (clk),
    .reset          (reset),
    .start_drive    (sd4),
    .start_recovery (sr4),
    .ratio          (ratio4),
    .on_drive       (on_drive4),
    .drive_count    (drive4),
    .recovery_count (rec4),
    .busy           (busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef RATIOER_SAT_EN
    exp_wrap_d = 32'd15;
    exp_rec4   = 32'd15;
    exp_ratio4 = 32'h1000_0000;
`else
    exp_wrap_d = 32'd0;
    exp_rec4   = 32'd4;
    exp_ratio4 = 32'hFFFF_FFFF;
`endif
    reset = 1'b1; sd = 1'b0; sr = 1'b0; sd4 = 1'b0; sr4 = 1'b0;

    // Reset state
    tick(2);
    check("rst_ratio", ratio, 32'd0);
    check("rst_drive", 32'(drive_count), 32'd0);
    check("rst_rec", 32'(recovery_count), 32'd0);
    check("rst_on_drive", 32'(on_drive), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_drive4", 32'(drive4), 32'd0);
    reset = 1'b0;

    // First drive from IDLE, 25 cycles, then recovery
    sd = 1'b1; tick(1); sd = 1'b0;
    check("d1_on_drive", 32'(on_drive), 32'd1);
    check("d1_drive", 32'(drive_count), 32'd1);
    check("d1_rec_hold", 32'(recovery_count), 32'd0);
    tick(24);
    check("d1_drive25", 32'(drive_count), 32'd25);
    sr = 1'b1; tick(1); sr = 1'b0;
    check("r1_drive_hold", 32'(drive_count), 32'd25);
    check("r1_rec", 32'(recovery_count), 32'd1);
    check("r1_on_drive", 32'(on_drive), 32'd0);
    check("r1_ratio", ratio, 32'd0);
    tick(3);
    check("r1_rec4", 32'(recovery_count), 32'd4);
    tick(46);
    check("r1_rec50", 32'(recovery_count), 32'd50);

    // Division 50/25 -> 0x200 after exactly 32 iterations
    sd = 1'b1; tick(1); sd = 1'b0;
    check("div1_busy", 32'(busy), 32'd1);
    check("div1_on_drive", 32'(on_drive), 32'd1);
    check("div1_rec_reload", 32'(recovery_count), 32'd1);
    tick(31);
    check("div1_busy_e31", 32'(busy), 32'd1);
    check("div1_ratio_e31", ratio, 32'd0);
    tick(1);
    check("div1_busy_e32", 32'(busy), 32'd0);
    check("div1_ratio", ratio, 32'h0000_0200);
    check("div1_drive33", 32'(drive_count), 32'd33);

    // start_drive while in DRIVE: counter reload, no division
    sd = 1'b1; tick(1); sd = 1'b0;
    check("dd_drive", 32'(drive_count), 32'd1);
    check("dd_busy", 32'(busy), 32'd0);

    // Drive 3, recovery 10 -> 853; second start_drive mid-division ignored
    tick(2);
    sr = 1'b1; tick(1); sr = 1'b0;
    check("d3_drive", 32'(drive_count), 32'd3);
    tick(9);
    check("r10_rec", 32'(recovery_count), 32'd10);
    sd = 1'b1; tick(1); sd = 1'b0;
    tick(4);
    sd = 1'b1; tick(1); sd = 1'b0;
    check("div2_busy_e5", 32'(busy), 32'd1);
    tick(26);
    check("div2_ratio_e31", ratio, 32'h0000_0200);
    tick(1);
    check("div2_ratio", ratio, 32'd853);
    check("div2_busy", 32'(busy), 32'd0);
    tick(10);
    check("div2_ratio_hold", ratio, 32'd853);

    // Both starts together in RECOVERY: drive wins, division 12/4 -> 0x300
    sd = 1'b1; tick(1); sd = 1'b0;
    tick(3);
    sr = 1'b1; tick(1); sr = 1'b0;
    tick(11);
    check("both_rec12", 32'(recovery_count), 32'd12);
    sd = 1'b1; sr = 1'b1; tick(1); sd = 1'b0; sr = 1'b0;
    check("both_on_drive", 32'(on_drive), 32'd1);
    check("both_busy", 32'(busy), 32'd1);
    check("both_drive", 32'(drive_count), 32'd1);
    tick(1);
    check("both_drive2", 32'(drive_count), 32'd2);
    tick(31);
    check("both_ratio", ratio, 32'h0000_0300);
    check("both_drive33", 32'(drive_count), 32'd33);

    // Reset at iteration 10 of a division, with start_drive also high
    sr = 1'b1; tick(1); sr = 1'b0;
    tick(5);
    sd = 1'b1; tick(1); sd = 1'b0;
    tick(9);
    reset = 1'b1; sd = 1'b1; tick(1); reset = 1'b0; sd = 1'b0;
    check("mrst_ratio", ratio, 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_on_drive", 32'(on_drive), 32'd0);
    check("mrst_drive", 32'(drive_count), 32'd0);
    check("mrst_rec", 32'(recovery_count), 32'd0);
    tick(40);
    check("mrst_ratio_late", ratio, 32'd0);
    check("mrst_busy_late", 32'(busy), 32'd0);

    // 4-bit counters: wrap or saturate, then divide-by-zero / full-scale
    sd4 = 1'b1; tick(1); sd4 = 1'b0;
    tick(14);
    check("c4_drive15", 32'(drive4), 32'd15);
    tick(1);
    check("c4_drive_edge", 32'(drive4), exp_wrap_d);
    sr4 = 1'b1; tick(1); sr4 = 1'b0;
    check("c4_rec1", 32'(rec4), 32'd1);
    tick(19);
    check("c4_rec20", 32'(rec4), exp_rec4);
    sd4 = 1'b1; tick(1); sd4 = 1'b0;
    check("c4_busy", 32'(busy4), 32'd1);
    tick(31);
    check("c4_ratio_e31", ratio4, 32'd0);
    tick(1);
    check("c4_ratio", ratio4, exp_ratio4);
    check("c4_busy_done", 32'(busy4), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
